// File: rtl/ram_stream_reader.sv
// Block-read engine: walks a wrapping address range of a 1-cycle-latency RAM and streams the words out valid/ready.
// Define RAM_READER_LAST_EN to add the m_last output and its beat tracking.
module ram_stream_reader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
`ifdef RAM_READER_LAST_EN
  ,
  output logic              m_last
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t            state;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   issue_cnt;
  logic              vld_p0;
  logic              vld_p1;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_count;
  logic [2:0]        occ;
  logic              pop;
  logic              last_issue;
  logic              final_pop;

  assign m_valid    = (fifo_count != 2'd0);
  assign pop        = m_valid && m_ready;
  // Words already owed to the FIFO after this cycle's pop; a new read may only go out if one slot stays free.
  assign occ        = 3'(fifo_count) + 3'(vld_p1) - 3'(pop);
  assign vld_p0     = (state == RUN) && (occ < 3'd2);
  assign last_issue = vld_p0 && (issue_cnt == len_r - (ADDR_W+1)'(1));
  assign final_pop  = (state == DRAIN) && pop && (fifo_count == 2'd1) && !vld_p1;
  assign m_data     = m_valid ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      ram_read_addr <= '0;
      len_r         <= '0;
      issue_cnt     <= '0;
      vld_p1        <= 1'b0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      fifo_count    <= 2'd0;
    end else begin
      done <= 1'b0;
      // p0 -> p1: address registered by the RAM, its word is on ram_q next cycle
      vld_p1     <= vld_p0;
      fifo_count <= fifo_count + 2'(vld_p1) - 2'(pop);
      if (vld_p1) wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
      if (vld_p0) begin
        issue_cnt <= issue_cnt + (ADDR_W+1)'(1);
        if (!last_issue) ram_read_addr <= ram_read_addr + ADDR_W'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              state         <= RUN;
              busy          <= 1'b1;
              len_r         <= len;
              issue_cnt     <= '0;
              ram_read_addr <= base_addr;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (last_issue) state <= DRAIN;
        end
        DRAIN: begin
          if (final_pop) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // p1 -> FIFO: capture the RAM word at the end of the cycle it is presented
  always_ff @(posedge clk) begin
    if (vld_p1) fifo_mem[wr_ptr] <= ram_q;
  end

`ifdef RAM_READER_LAST_EN
  logic [ADDR_W:0] beat_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (state == IDLE && start) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + (ADDR_W+1)'(1);
    end
  end

  assign m_last = m_valid && (beat_cnt == len_r - (ADDR_W+1)'(1));
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader with a behavioural 64x8 RAM and a scoreboard of expected beats.
module tb_ram_stream_reader;
  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] base_addr;
  logic [6:0] len;
  logic       busy;
  logic       done;
  logic [5:0] ram_read_addr;
  logic [7:0] ram_q;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
`ifdef RAM_READER_LAST_EN
  logic       m_last;
`endif

  logic [7:0] mem [64];
  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  ram_stream_reader #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .ram_read_addr(ram_read_addr), .ram_q(ram_q),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
`ifdef RAM_READER_LAST_EN
    , .m_last(m_last)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= mem[ram_read_addr];

  task automatic start_block(input logic [5:0] b, input logic [6:0] l);
    base_addr = b;
    len = l;
    start = 1'b1;
    for (int i = 0; i < int'(l); i++) exp_q.push_back(mem[(int'(b) + i) % 64]);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", m_data); end
    checks++; if (ram_read_addr !== 6'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", ram_read_addr); end
`ifdef RAM_READER_LAST_EN
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", m_last); end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy %b valid %b want 0 0", busy, m_valid); end
  endtask

  task automatic test_basic();
    int cyc = 0, first = -1, lastc = -1, beats = 0, dones = 0, donec = -1;
    logic [7:0] e;
    m_ready = 1'b1;
    start_block(6'd0, 7'd8);
    while (cyc < 40) begin
      if (m_valid && first < 0) first = cyc;
      if (done) begin dones++; donec = cyc; end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL basic_extra_beat got %h want none", m_data); end
        else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin errors++; $display("FAIL basic_data got %h want %h", m_data, e); end
`ifdef RAM_READER_LAST_EN
          checks++;
          if (m_last !== (exp_q.size() == 0)) begin errors++; $display("FAIL basic_last got %b want %b", m_last, exp_q.size() == 0); end
`endif
        end
        beats++; lastc = cyc;
      end
      @(posedge clk); #1; cyc++;
    end
    checks++; if (first != 2) begin errors++; $display("FAIL basic_latency got %0d want 2", first); end
    checks++; if (beats != 8 || lastc != first + 7) begin errors++; $display("FAIL basic_throughput beats %0d last %0d want 8 %0d", beats, lastc, first + 7); end
    checks++; if (dones != 1 || donec != lastc + 1) begin errors++; $display("FAIL basic_done count %0d at %0d want 1 at %0d", dones, donec, lastc + 1); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing got %0d left want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    int cyc = 0, beats = 0, dones = 0;
    logic [5:0] want_addr [4] = '{6'd62, 6'd63, 6'd0, 6'd1};
    logic [7:0] e;
    m_ready = 1'b1;
    start_block(6'd62, 7'd4);
    while (cyc < 20) begin
      if (cyc < 4) begin
        checks++;
        if (ram_read_addr !== want_addr[cyc]) begin errors++; $display("FAIL wrap_addr%0d got %0d want %0d", cyc, ram_read_addr, want_addr[cyc]); end
      end
      if (done) dones++;
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL wrap_extra_beat got %h want none", m_data); end
        else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin errors++; $display("FAIL wrap_data got %h want %h", m_data, e); end
        end
        beats++;
      end
      @(posedge clk); #1; cyc++;
    end
    checks++; if (beats != 4 || dones != 1) begin errors++; $display("FAIL wrap_count beats %0d dones %0d want 4 1", beats, dones); end
    checks++; if (ram_read_addr !== 6'd1) begin errors++; $display("FAIL wrap_addr_hold got %0d want 1", ram_read_addr); end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    int cyc = 0, beats = 0, dones = 0;
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic stalled = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] e;
    m_ready = 1'b1;
    start_block(6'd20, 7'd6);
    while (cyc < 60) begin
      m_ready = pat[cyc % 6];
      if (stalled) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== held) begin errors++; $display("FAIL bp_stable got %h valid %b want %h valid 1", m_data, m_valid, held); end
      end
      if (done) dones++;
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra_beat got %h want none", m_data); end
        else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin errors++; $display("FAIL bp_data got %h want %h", m_data, e); end
        end
        beats++;
      end
      stalled = m_valid && !m_ready;
      held = m_data;
      @(posedge clk); #1; cyc++;
    end
    checks++; if (beats != 6 || dones != 1 || exp_q.size() != 0) begin errors++; $display("FAIL bp_count beats %0d dones %0d left %0d want 6 1 0", beats, dones, exp_q.size()); end
    m_ready = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_len0_and_ignore();
    int cyc = 0, beats = 0, dones = 0, valids = 0, busys = 0;
    logic [5:0] addr0;
    logic [7:0] e;
    m_ready = 1'b1;
    addr0 = ram_read_addr;
    start_block(6'd30, 7'd0);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL len0_done got done %b busy %b want 1 0", done, busy); end
    while (cyc < 6) begin
      if (done) dones++;
      if (m_valid) valids++;
      if (busy) busys++;
      @(posedge clk); #1; cyc++;
    end
    checks++; if (dones != 1 || valids != 0 || busys != 0) begin errors++; $display("FAIL len0_quiet dones %0d valids %0d busys %0d want 1 0 0", dones, valids, busys); end
    checks++; if (ram_read_addr !== addr0) begin errors++; $display("FAIL len0_addr got %0d want %0d", ram_read_addr, addr0); end

    cyc = 0; dones = 0;
    start_block(6'd0, 7'd3);
    while (cyc < 30) begin
      if (cyc == 1) begin start = 1'b1; base_addr = 6'd40; len = 7'd5; end
      else start = 1'b0;
      if (done) dones++;
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL ignore_extra_beat got %h want none", m_data); end
        else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin errors++; $display("FAIL ignore_data got %h want %h", m_data, e); end
`ifdef RAM_READER_LAST_EN
          checks++;
          if (m_last !== (exp_q.size() == 0)) begin errors++; $display("FAIL ignore_last got %b want %b", m_last, exp_q.size() == 0); end
`endif
        end
        beats++;
      end
      @(posedge clk); #1; cyc++;
    end
    checks++; if (beats != 3 || dones != 1) begin errors++; $display("FAIL ignore_count beats %0d dones %0d want 3 1", beats, dones); end
    exp_q.delete();
  endtask

  task automatic test_mid_reset();
    int cyc = 0, beats = 0, dones = 0, valids = 0;
    logic [7:0] e;
    m_ready = 1'b1;
    start_block(6'd0, 7'd10);
    while (beats < 3 && cyc < 20) begin
      if (m_valid && m_ready) begin
        checks++;
        e = exp_q.pop_front();
        if (m_data !== e) begin errors++; $display("FAIL mid_data got %h want %h", m_data, e); end
        beats++;
      end
      @(posedge clk); #1; cyc++;
    end
    checks++; if (beats != 3) begin errors++; $display("FAIL mid_timeout got %0d beats want 3", beats); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || ram_read_addr !== 6'd0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_reset_state valid %b busy %b addr %0d done %b want 0 0 0 0", m_valid, busy, ram_read_addr, done);
    end
    for (int i = 0; i < 6; i++) begin
      if (done) dones++;
      if (m_valid) valids++;
      @(posedge clk); #1;
    end
    checks++; if (dones != 0 || valids != 0) begin errors++; $display("FAIL mid_quiet dones %0d valids %0d want 0 0", dones, valids); end
    exp_q.delete();

    cyc = 0; beats = 0; dones = 0;
    start_block(6'd5, 7'd2);
    while (cyc < 15) begin
      if (done) dones++;
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL after_extra_beat got %h want none", m_data); end
        else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin errors++; $display("FAIL after_data got %h want %h", m_data, e); end
        end
        beats++;
      end
      @(posedge clk); #1; cyc++;
    end
    checks++; if (beats != 2 || dones != 1) begin errors++; $display("FAIL after_count beats %0d dones %0d want 2 1", beats, dones); end
    exp_q.delete();
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    len = '0;
    m_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i + 16);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len0_and_ignore();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
